// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  // Address bits needed to index n entries (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write bus of the register file; ports are packed per the flat layout.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2
);
  localparam int AW = clog2(NREGS);

  logic [NRD-1:0]      ren;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rvalid;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                busy;

  modport master (
    output ren, raddr, we, waddr, wdata,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  ren, raddr, we, waddr, wdata,
    output rdata, rvalid, busy
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: zero-entry, busy and write-bypass muxing.
// Write-first bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_rd_port #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter bit ZERO0 = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ren,
  input  logic [AW-1:0]   raddr,
  input  logic            busy,
  input  logic [XLEN-1:0] raw_data,
  input  logic            wr_hit,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            rvalid
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] rdata_reg;
  logic            rvalid_reg;

  always_comb begin
    sel_data = raw_data;
    if (BYPASS && wr_hit) sel_data = wdata;
    if (busy || (ZERO0 && (raddr == '0))) sel_data = '0;
  end

  // rdata holds its last value whenever the port is not enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rvalid_reg <= ren;
      if (ren) rdata_reg <= sel_data;
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;

endmodule

// File: rtl/regfile_mp.sv
// NRD-read / 1-write register file with a post-reset hardware clear sweep.
// Optional write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  parameter bit ZERO0 = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  localparam int AW = clog2(NREGS);

  logic [XLEN-1:0] mem [NREGS];

  rf_state_t       state_reg, state_next;
  logic [AW-1:0]   ptr_reg, ptr_next;
  logic            busy;
  logic            wr_eff;
  logic [XLEN-1:0] rd_data [NRD];
  logic [NRD-1:0]  rd_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RF_CLEAR;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      RF_CLEAR: begin
        if (ptr_reg == AW'(NREGS - 1)) begin
          state_next = RF_IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      RF_IDLE: ;
    endcase
  end

  assign busy     = (state_reg == RF_CLEAR);
  assign bus.busy = busy;

  assign wr_eff = bus.we && !busy && !reset
                  && (int'(bus.waddr) < NREGS)
                  && !(ZERO0 && (bus.waddr == '0));

  // Sweep and functional writes share the single write port.
  always_ff @(posedge clk) begin
    if (busy && !reset) begin
      mem[ptr_reg] <= '0;
    end else if (wr_eff) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] raw;
      logic            hit;

      assign ra  = bus.raddr[gi*AW +: AW];
      assign raw = (int'(ra) < NREGS) ? mem[ra] : '0;
      assign hit = wr_eff && (bus.waddr == ra);

      regfile_rd_port #(
        .XLEN  (XLEN),
        .AW    (AW),
        .ZERO0 (ZERO0)
      ) u_port (
        .clk      (clk),
        .reset    (reset),
        .ren      (bus.ren[gi]),
        .raddr    (ra),
        .busy     (busy),
        .raw_data (raw),
        .wr_hit   (hit),
        .wdata    (bus.wdata),
        .rdata    (rd_data[gi]),
        .rvalid   (rd_valid[gi])
      );
    end
  endgenerate

  always_comb begin
    bus.rdata = '0;
    for (int p = 0; p < NRD; p++) begin
      bus.rdata[p*XLEN +: XLEN] = rd_data[p];
    end
    bus.rvalid = rd_valid;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (2 read ports, 32x32, ZERO0=1).
module tb_regfile_mp;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cnt;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO0(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("ok   %-14s observed=%h expected=%h", tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] en, input logic [4:0] a1, input logic [4:0] a0);
    bus.ren   = en;
    bus.raddr = {a1, a0};
  endtask

  task automatic wr(input logic w, input logic [4:0] a, input logic [31:0] d);
    bus.we    = w;
    bus.waddr = a;
    bus.wdata = d;
  endtask

  logic [31:0] exp_t4;

  initial begin
    reset = 1'b1;
    rd(2'b00, 5'd0, 5'd0);
    wr(1'b0, 5'd0, 32'h0);

    // Reset state and a one-cycle reset pulse
    tick();
    chk("rst_busy", {31'b0, bus.busy}, 32'h1);
    chk("rst_rvalid", {30'b0, bus.rvalid}, 32'h0);
    chk("rst_rdata", bus.rdata[31:0], 32'h0);
    reset = 1'b0;
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.busy) break;
      cnt++;
    end
    chk("busy_cycles", cnt, 32'd32);

    for (int a = 1; a < 32; a++) begin
      rd(2'b11, 5'(a), 5'(a));
      tick();
      chk("clr_p0", bus.rdata[31:0], 32'h0);
      chk("clr_p1", bus.rdata[63:32], 32'h0);
    end
    chk("clr_rvalid", {30'b0, bus.rvalid}, 32'h3);

    // Write then read from both ports
    rd(2'b00, 5'd0, 5'd0);
    wr(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(2'b11, 5'd5, 5'd5);
    tick();
    chk("r5_p0", bus.rdata[31:0], 32'hDEADBEEF);
    chk("r5_p1", bus.rdata[63:32], 32'hDEADBEEF);
    chk("r5_rvalid", {30'b0, bus.rvalid}, 32'h3);

    // Entry 0 is hard-wired to zero
    rd(2'b00, 5'd0, 5'd0);
    wr(1'b1, 5'd0, 32'h1234);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(2'b01, 5'd0, 5'd0);
    tick();
    chk("r0_zero", bus.rdata[31:0], 32'h0);
    chk("r0_rvalid", {30'b0, bus.rvalid}, 32'h1);

    // Same-cycle write and read of r7
    rd(2'b00, 5'd0, 5'd0);
    wr(1'b1, 5'd7, 32'h11);
    tick();
    wr(1'b1, 5'd7, 32'hA5A5A5A5);
    rd(2'b01, 5'd0, 5'd7);
    tick();
`ifdef REGFILE_BYPASS_EN
    exp_t4 = 32'hA5A5A5A5;
`else
    exp_t4 = 32'h11;
`endif
    chk("r7_same_cyc", bus.rdata[31:0], exp_t4);
    wr(1'b0, 5'd0, 32'h0);
    tick();
    chk("r7_next_cyc", bus.rdata[31:0], 32'hA5A5A5A5);

    // Hold behaviour with ren low
    rd(2'b00, 5'd0, 5'd0);
    wr(1'b1, 5'd9, 32'hCAFE);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(2'b10, 5'd9, 5'd0);
    tick();
    chk("r9_read", bus.rdata[63:32], 32'hCAFE);
    chk("r9_rvalid", {30'b0, bus.rvalid}, 32'h2);
    rd(2'b00, 5'd9, 5'd0);
    wr(1'b1, 5'd9, 32'hBEEF);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    chk("hold_data", bus.rdata[63:32], 32'hCAFE);
    chk("hold_rvalid", {30'b0, bus.rvalid}, 32'h0);
    tick();
    chk("hold_data2", bus.rdata[63:32], 32'hCAFE);
    rd(2'b10, 5'd9, 5'd0);
    tick();
    chk("r9_new", bus.rdata[63:32], 32'hBEEF);

    // Reset reasserted mid-sweep restarts the full sweep
    rd(2'b00, 5'd0, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", {31'b0, bus.busy}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 1;
    wr(1'b1, 5'd12, 32'h5555);
    rd(2'b01, 5'd0, 5'd5);
    tick();
    chk("busy_rd_data", bus.rdata[31:0], 32'h0);
    chk("busy_rd_valid", {30'b0, bus.rvalid}, 32'h1);
    wr(1'b0, 5'd0, 32'h0);
    rd(2'b00, 5'd0, 5'd0);
    if (bus.busy) cnt++;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.busy) break;
      cnt++;
    end
    chk("rebusy_cycles", cnt, 32'd32);
    rd(2'b11, 5'd5, 5'd12);
    tick();
    chk("dropped_r12", bus.rdata[31:0], 32'h0);
    chk("swept_r5", bus.rdata[63:32], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
